pc_target_table: RTL and testbench

- Programmable branch-target table for the fetch stage; the parametrised successor of the fixed, hard-coded branch LUT.
- Entries are written at run time by a program-loader port.
- Each entry carries a valid bit and an absolute/relative mode.
- Lookups are registered (1-cycle latency) and return the next-PC target; an invalid entry returns "hold PC".

---
 rtl/pc_target_table.sv | 99 +++++++++
 tb/tb_pc_target_table.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_target_table.sv
// Run-time programmable branch-target table: a loader port fills entries, and the
// fetch stage issues registered lookups that return the next PC (or hold PC on a miss).
module pc_target_table #(
  parameter int unsigned D = 9,
  parameter int unsigned A = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D:0]   wr_target,
  input  logic         wr_rel,
  input  logic         lk_valid,
  input  logic [A-1:0] lk_addr,
  input  logic [D:0]   lk_pc,
  output logic         ready,
  output logic         tgt_valid,
  output logic [D:0]   target,
  output logic         hit
);

  localparam int unsigned DEPTH = 2 ** A;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t          state;
  logic [A-1:0]    cnt;

  logic [DEPTH-1:0] valid_mem;
  logic             rel_mem  [DEPTH];
  logic [D:0]       data_mem [DEPTH];

  logic             fwd;
  logic             sel_valid;
  logic             sel_rel;
  logic [D:0]       sel_data;
  logic [D:0]       next_target;

  // A write landing in the same cycle as a lookup of the same entry is
  // forwarded so the lookup observes the freshly written contents.
  always_comb begin
    fwd         = wr_en && (wr_addr == lk_addr);
    sel_valid   = fwd ? 1'b1      : valid_mem[lk_addr];
    sel_rel     = fwd ? wr_rel    : rel_mem[lk_addr];
    sel_data    = fwd ? wr_target : data_mem[lk_addr];
    next_target = lk_pc;
    if (sel_valid) begin
      if (sel_rel) begin
        next_target = lk_pc + sel_data;
      end else begin
        next_target = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      ready     <= 1'b0;
      tgt_valid <= 1'b0;
      target    <= '0;
      hit       <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          valid_mem[cnt] <= 1'b0;
          cnt            <= cnt + 1'b1;
          tgt_valid      <= 1'b0;
          if (cnt == '1) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wr_en) begin
            valid_mem[wr_addr] <= 1'b1;
            rel_mem[wr_addr]   <= wr_rel;
            data_mem[wr_addr]  <= wr_target;
          end
          tgt_valid <= lk_valid;
          if (lk_valid) begin
            target <= next_target;
            hit    <= sel_valid;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_target_table.sv
// Directed self-checking bench for pc_target_table with D=9, A=5.
module tb_pc_target_table;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [9:0] wr_target;
  logic       wr_rel;
  logic       lk_valid;
  logic [4:0] lk_addr;
  logic [9:0] lk_pc;
  logic       ready;
  logic       tgt_valid;
  logic [9:0] target;
  logic       hit;

  int n_checks;
  int n_fail;

  pc_target_table #(.D(9), .A(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_target (wr_target),
    .wr_rel    (wr_rel),
    .lk_valid  (lk_valid),
    .lk_addr   (lk_addr),
    .lk_pc     (lk_pc),
    .ready     (ready),
    .tgt_valid (tgt_valid),
    .target    (target),
    .hit       (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    lk_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 5'd9;
    wr_target = 10'd77;
    wr_rel    = 1'b0;
    lk_valid  = 1'b1;
    lk_addr   = 5'd9;
    lk_pc     = 10'd50;
    tick();
    tick();
    n_checks++;
    if ({ready, tgt_valid, target, hit} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%0b tgt_valid=%0b target=%0d hit=%0b, expected all 0",
               ready, tgt_valid, target, hit);
    end
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      n_checks++;
      if (ready !== 1'b0 || tgt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL init_busy cycle %0d: ready=%0b tgt_valid=%0b, expected 0 0", k, ready, tgt_valid);
      end
    end
    tick();
    n_checks++;
    if (ready !== 1'b1 || tgt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done: ready=%0b tgt_valid=%0b, expected 1 0", ready, tgt_valid);
    end
    idle();
    tick();
  endtask

  task automatic test_abs();
    wr_en = 1'b1; wr_addr = 5'd3; wr_target = 10'd23; wr_rel = 1'b0;
    tick();
    wr_en = 1'b0;
    lk_valid = 1'b1; lk_addr = 5'd3; lk_pc = 10'd100;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'd23 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL abs_lookup: tgt_valid=%0b target=%0d hit=%0b, expected 1 23 1", tgt_valid, target, hit);
    end
    lk_valid = 1'b0; lk_pc = 10'd400;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b0 || target !== 10'd23 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_hold: tgt_valid=%0b target=%0d hit=%0b, expected 0 23 1", tgt_valid, target, hit);
    end
  endtask

  task automatic test_rel();
    wr_en = 1'b1; wr_addr = 5'd1; wr_target = 10'h3FB; wr_rel = 1'b1;
    tick();
    wr_en = 1'b0;
    lk_valid = 1'b1; lk_addr = 5'd1; lk_pc = 10'd4;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'h3FF || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_neg_wrap: tgt_valid=%0b target=%h hit=%0b, expected 1 3ff 1", tgt_valid, target, hit);
    end
    lk_pc = 10'd10;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'd5 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_carry_drop: tgt_valid=%0b target=%0d hit=%0b, expected 1 5 1", tgt_valid, target, hit);
    end
    idle();
    tick();
  endtask

  task automatic test_miss();
    lk_valid = 1'b1; lk_addr = 5'd7; lk_pc = 10'd200;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'd200 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_hold_pc: tgt_valid=%0b target=%0d hit=%0b, expected 1 200 0", tgt_valid, target, hit);
    end
    lk_addr = 5'd9; lk_pc = 10'd50;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'd50 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL init_write_ignored: tgt_valid=%0b target=%0d hit=%0b, expected 1 50 0", tgt_valid, target, hit);
    end
    idle();
    tick();
  endtask

  task automatic test_forward();
    wr_en = 1'b1; wr_addr = 5'd5; wr_target = 10'd39; wr_rel = 1'b0;
    lk_valid = 1'b1; lk_addr = 5'd5; lk_pc = 10'd0;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'd39 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_first: tgt_valid=%0b target=%0d hit=%0b, expected 1 39 1", tgt_valid, target, hit);
    end
    wr_target = 10'd55;
    tick();
    n_checks++;
    if (target !== 10'd55 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_overwrite: target=%0d hit=%0b, expected 55 1", target, hit);
    end
    wr_addr = 5'd6; wr_target = 10'd66; lk_addr = 5'd3;
    tick();
    n_checks++;
    if (target !== 10'd23 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL diff_addr_independent: target=%0d hit=%0b, expected 23 1", target, hit);
    end
    wr_en = 1'b0; lk_addr = 5'd6;
    tick();
    n_checks++;
    if (target !== 10'd66 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL diff_addr_written: target=%0d hit=%0b, expected 66 1", target, hit);
    end
    lk_addr = 5'd5;
    tick();
    n_checks++;
    if (target !== 10'd55 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_stored: target=%0d hit=%0b, expected 55 1", target, hit);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    lk_valid = 1'b1; lk_pc = 10'd100;
    lk_addr = 5'd3;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'd23 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_0: tgt_valid=%0b target=%0d hit=%0b, expected 1 23 1", tgt_valid, target, hit);
    end
    lk_addr = 5'd1;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'd95 || hit !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_1: tgt_valid=%0b target=%0d hit=%0b, expected 1 95 1", tgt_valid, target, hit);
    end
    lk_addr = 5'd7;
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'd100 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_2: tgt_valid=%0b target=%0d hit=%0b, expected 1 100 0", tgt_valid, target, hit);
    end
    idle();
    tick();
  endtask

  task automatic test_reinit();
    wr_en = 1'b1; wr_addr = 5'd2; wr_target = 10'd10; wr_rel = 1'b0;
    tick();
    wr_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lk_valid = 1'b1; lk_addr = 5'd2; lk_pc = 10'd8;
    for (int k = 1; k <= 31; k++) tick();
    n_checks++;
    if (ready !== 1'b0 || tgt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reinit_restart: ready=%0b tgt_valid=%0b, expected 0 0", ready, tgt_valid);
    end
    tick();
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reinit_ready: ready=%0b, expected 1", ready);
    end
    tick();
    n_checks++;
    if (tgt_valid !== 1'b1 || target !== 10'd8 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reinit_cleared: tgt_valid=%0b target=%0d hit=%0b, expected 1 8 0", tgt_valid, target, hit);
    end
    idle();
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_target = '0;
    wr_rel    = 1'b0;
    lk_valid  = 1'b0;
    lk_addr   = '0;
    lk_pc     = '0;
    test_reset();
    test_abs();
    test_rel();
    test_miss();
    test_forward();
    test_back_to_back();
    test_reinit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
